// File: rtl/memctrl_pkg.sv
// Shared encodings and bus types for the memory controller and its fetch engine.
package memctrl_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef logic [7:0]  ByteBus;
  typedef logic [31:0] DataAddrBus;
  typedef logic [31:0] InstBus;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_I0   = 3'd1,
    FS_I1   = 3'd2,
    FS_I2   = 3'd3,
    FS_I3   = 3'd4,
    FS_C3   = 3'd5
  } fetch_state_e;

  // Byte offset from the latched PC presented in each issue state.
  function automatic logic [1:0] fetch_offset(input fetch_state_e s);
    logic [1:0] off;
    case (s)
      FS_I1:   off = 2'd1;
      FS_I2:   off = 2'd2;
      FS_I3:   off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

  function automatic logic is_mem_req(input logic [1:0] rw);
    return (rw == RW_READ) || (rw == RW_WRITE);
  endfunction

endpackage

// File: rtl/memctrl_fetch.sv
// Instruction fetch engine: issues four byte reads and assembles a little-endian word,
// restarting from byte 0 whenever the MEM stage takes the RAM port.
module memctrl_fetch
  import memctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_flush,
  input  logic              mem_busy,
  input  logic [7:0]        mem_din,
  output logic              issue,
  output logic [ADDR_W-1:0] fetch_a,
  output logic [31:0]       inst_o,
  output logic              inst_valid,
  output logic              if_busy
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;

  // State, latched PC and partial instruction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FS_IDLE;
      pc_q    <= {ADDR_W{1'b0}};
      inst_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state: each granted Ik cycle captures the byte issued in the previous cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (if_flush) begin
      state_d = FS_IDLE;
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (if_req) begin
            state_d = FS_I0;
            pc_d    = if_pc;
          end else begin
            state_d = FS_IDLE;
          end
        end
        FS_I0: begin
          if (mem_busy) state_d = FS_I0;
          else          state_d = FS_I1;
        end
        FS_I1: begin
          if (mem_busy) begin
            state_d = FS_I0;
          end else begin
            state_d      = FS_I2;
            inst_d[7:0]  = mem_din;
          end
        end
        FS_I2: begin
          if (mem_busy) begin
            state_d = FS_I0;
          end else begin
            state_d      = FS_I3;
            inst_d[15:8] = mem_din;
          end
        end
        FS_I3: begin
          if (mem_busy) begin
            state_d = FS_I0;
          end else begin
            state_d       = FS_C3;
            inst_d[23:16] = mem_din;
          end
        end
        FS_C3: begin
          state_d       = FS_IDLE;
          inst_d[31:24] = mem_din;
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  // The last byte arrives during C3, so the word is completed straight from the RAM data.
  always_comb begin
    issue      = (state_q == FS_I0) || (state_q == FS_I1) ||
                 (state_q == FS_I2) || (state_q == FS_I3);
    fetch_a    = pc_q + ADDR_W'(fetch_offset(state_q));
    if_busy    = (state_q != FS_IDLE);
    inst_valid = (state_q == FS_C3) && !if_flush;
    if (state_q == FS_C3) begin
      inst_o = {mem_din, inst_q[23:0]};
    end else begin
      inst_o = inst_q;
    end
  end

endmodule

// File: rtl/memctrl.sv
// Memory controller: shares one byte-wide RAM port between the MEM stage (absolute
// priority, zero added latency) and the instruction fetch engine.
module memctrl
  import memctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rw_to_memctrl,
  input  logic [ADDR_W-1:0] addr_to_memctrl,
  input  logic [7:0]        data_to_memctrl,
  output logic [7:0]        data_from_memctrl,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_flush,
  output logic [31:0]       inst_o,
  output logic              inst_valid,
  output logic              if_busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din
);

  logic              mem_req;
  logic              fetch_issue;
  logic [ADDR_W-1:0] fetch_a;

  assign mem_req = is_mem_req(rw_to_memctrl);

  memctrl_fetch #(.ADDR_W(ADDR_W)) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .if_flush   (if_flush),
    .mem_busy   (mem_req),
    .mem_din    (mem_din),
    .issue      (fetch_issue),
    .fetch_a    (fetch_a),
    .inst_o     (inst_o),
    .inst_valid (inst_valid),
    .if_busy    (if_busy)
  );

  // Port mux; everything is held at zero while reset is asserted so no stray write escapes.
  always_comb begin
    mem_a             = {ADDR_W{1'b0}};
    mem_wr            = 1'b0;
    mem_dout          = 8'h00;
    data_from_memctrl = 8'h00;
    if (rst) begin
      data_from_memctrl = mem_din;
      if (mem_req) begin
        mem_a    = addr_to_memctrl;
        mem_dout = data_to_memctrl;
        mem_wr   = (rw_to_memctrl == RW_WRITE);
      end else if (fetch_issue) begin
        mem_a = fetch_a;
      end else begin
        mem_a = {ADDR_W{1'b0}};
      end
    end else begin
      data_from_memctrl = 8'h00;
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// Self-checking bench for memctrl: directed scenarios plus randomized traffic against a
// transaction-level model (fetch progress counter, RAM array, pending MEM read).
module tb_memctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rw = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  data_from;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        if_flush = 1'b0;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        if_busy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'h00;

  memctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .rw_to_memctrl(rw), .addr_to_memctrl(addr), .data_to_memctrl(wdata),
    .data_from_memctrl(data_from),
    .if_req(if_req), .if_pc(if_pc), .if_flush(if_flush),
    .inst_o(inst_o), .inst_valid(inst_valid), .if_busy(if_busy),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  // 4 KiB synchronous RAM aliased over the whole address space.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Model: fetch is "busy" with m_k bytes presented; m_k==4 is the completion cycle.
  bit          m_busy = 1'b0;
  logic [31:0] m_pc = 32'h0;
  int          m_k = 0;
  bit          pend_rd = 1'b0;
  logic [7:0]  pend_byte = 8'h00;

  always @(negedge clk) begin
    logic        memreq;
    logic [31:0] ea;
    logic [31:0] fa;
    logic [31:0] word;
    logic        ewr;
    logic        ev;
    if (!rst) begin
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
      chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
      chk("rst_data_from", {24'h0, data_from}, 32'h0);
      chk("rst_inst_o", inst_o, 32'h0);
      chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_if_busy", {31'h0, if_busy}, 32'h0);
      m_busy  = 1'b0;
      m_k     = 0;
      pend_rd = 1'b0;
    end else begin
      memreq = (rw == 2'b01) || (rw == 2'b10);
      ewr = 1'b0;
      if (memreq) begin
        ea  = addr;
        ewr = (rw == 2'b10);
        chk("mem_dout", {24'h0, mem_dout}, {24'h0, wdata});
      end else if (m_busy && m_k < 4) begin
        ea = m_pc + 32'(m_k);
      end else begin
        ea = 32'h0;
        chk("mem_dout_idle", {24'h0, mem_dout}, 32'h0);
      end
      chk("mem_a", mem_a, ea);
      chk("mem_wr", {31'h0, mem_wr}, {31'h0, ewr});
      if (pend_rd) chk("data_from", {24'h0, data_from}, {24'h0, pend_byte});
      pend_rd   = (rw == 2'b01);
      pend_byte = ram[addr[11:0]];
      ev = m_busy && (m_k == 4) && !if_flush;
      chk("inst_valid", {31'h0, inst_valid}, {31'h0, ev});
      chk("if_busy", {31'h0, if_busy}, {31'h0, m_busy});
      if (ev) begin
        for (int i = 0; i < 4; i++) begin
          fa = m_pc + 32'(i);
          word[8*i +: 8] = ram[fa[11:0]];
        end
        chk("inst_o", inst_o, word);
        done_cnt++;
      end
      if (if_flush) m_busy = 1'b0;
      else if (!m_busy) begin
        if (if_req) begin
          m_busy = 1'b1;
          m_pc   = if_pc;
          m_k    = 0;
        end
      end
      else if (m_k == 4) m_busy = 1'b0;
      else if (memreq) m_k = 0;
      else m_k++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [31:0] a, input logic [7:0] d);
    step();
    rw = 2'b10; addr = a; wdata = d;
  endtask

  // Uncontended fetch: address sequence pc..pc+3 then the word in the fifth cycle.
  task automatic fetch_check(input string name, input logic [31:0] pc, input logic [31:0] exp);
    step();
    rw = 2'b00; if_req = 1'b1; if_pc = pc;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk({name, "_addr"}, mem_a, pc + 32'(k));
      chk({name, "_novalid"}, {31'h0, inst_valid}, 32'h0);
    end
    step();
    @(negedge clk);
    chk({name, "_valid"}, {31'h0, inst_valid}, 32'h1);
    chk({name, "_word"}, inst_o, exp);
    step();
    if_req = 1'b0;
  endtask

  logic [7:0] load_bytes [0:3];
  int last_done = 0;

  initial begin
    load_bytes[0] = 8'h78; load_bytes[1] = 8'h56; load_bytes[2] = 8'h34; load_bytes[3] = 8'h12;
    repeat (3) step();
    rst = 1'b1;

    write_byte(32'h100, 8'h33); write_byte(32'h101, 8'h05);
    write_byte(32'h102, 8'hC5); write_byte(32'h103, 8'h00);
    write_byte(32'h200, 8'hEF); write_byte(32'h201, 8'hBE);
    write_byte(32'h202, 8'hAD); write_byte(32'h203, 8'hDE);
    write_byte(32'h40, 8'h78);  write_byte(32'h41, 8'h56);
    write_byte(32'h42, 8'h34);  write_byte(32'h43, 8'h12);
    write_byte(32'hFFFF_FFFE, 8'h11); write_byte(32'hFFFF_FFFF, 8'h22);
    write_byte(32'h0, 8'h33);   write_byte(32'h1, 8'h44);
    step();
    rw = 2'b00;

    // Reset in the middle of a fetch, with a write attempted while reset is low.
    step(); if_req = 1'b1; if_pc = 32'h100;
    step(); step();
    rst = 1'b0; rw = 2'b10; addr = 32'h300; wdata = 8'h5A;
    #2;
    chk("midrst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("midrst_mem_a", mem_a, 32'h0);
    chk("midrst_busy", {31'h0, if_busy}, 32'h0);
    chk("midrst_inst_o", inst_o, 32'h0);
    step(); if_req = 1'b0; rw = 2'b00;
    step(); rst = 1'b1;
    @(negedge clk);
    chk("postrst_busy", {31'h0, if_busy}, 32'h0);
    chk("postrst_valid", {31'h0, inst_valid}, 32'h0);

    fetch_check("fetch100", 32'h100, 32'h00C5_0533);

    // MEM write lands while the fetch is in I2: restart, word at T+8.
    step(); if_req = 1'b1; if_pc = 32'h100;
    step(); step(); step();
    rw = 2'b10; addr = 32'h20; wdata = 8'hAB;
    @(negedge clk);
    chk("prio_wr", {31'h0, mem_wr}, 32'h1);
    chk("prio_a", mem_a, 32'h20);
    chk("prio_dout", {24'h0, mem_dout}, 32'hAB);
    step(); rw = 2'b00;
    @(negedge clk);
    chk("prio_restart_a", mem_a, 32'h100);
    for (int i = 5; i < 8; i++) begin
      step();
      @(negedge clk);
      chk("prio_novalid", {31'h0, inst_valid}, 32'h0);
    end
    step();
    @(negedge clk);
    chk("prio_valid", {31'h0, inst_valid}, 32'h1);
    chk("prio_word", inst_o, 32'h00C5_0533);
    step(); if_req = 1'b0;

    // Four back-to-back MEM byte reads.
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) begin
        rw = 2'b01; addr = 32'h40 + 32'(i);
      end else begin
        rw = 2'b00;
      end
      @(negedge clk);
      if (i > 0) chk("load_byte", {24'h0, data_from}, {24'h0, load_bytes[i-1]});
    end

    // Flush in I2, then a fresh fetch at 0x200.
    step(); if_req = 1'b1; if_pc = 32'h100;
    step(); step(); step();
    if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'h0, inst_valid}, 32'h0);
    step(); if_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {31'h0, if_busy}, 32'h0);
    fetch_check("fetch200", 32'h200, 32'hDEAD_BEEF);

    fetch_check("wrap", 32'hFFFF_FFFE, 32'h4433_2211);

    // Randomized traffic; the negedge model checks every cycle.
    last_done = done_cnt;
    for (int c = 0; c < 4000; c++) begin
      step();
      case ($urandom % 8)
        0: rw = 2'b01;
        1: rw = 2'b10;
        2: rw = 2'b11;
        default: rw = 2'b00;
      endcase
      addr     = $urandom;
      wdata    = 8'($urandom);
      if_flush = (($urandom % 32) == 0);
      if (done_cnt != last_done) begin
        last_done = done_cnt;
        if_req = 1'($urandom % 2);
        if_pc  = $urandom;
      end else if (if_flush) begin
        if_req = 1'($urandom % 2);
        if_pc  = $urandom;
      end else if (!if_req && (($urandom % 4) == 0)) begin
        if_req = 1'b1;
        if_pc  = $urandom;
      end
      if (c == 2000 || c == 2001) rst = 1'b0;
      else rst = 1'b1;
    end
    step();
    rw = 2'b00; if_req = 1'b0; if_flush = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
